// File: rtl/data_mem_responder.sv
// Word-organised, big-endian byte-lane data memory answering the core's data port.
// Fixed-latency read pipeline with write-first forwarding, sticky range error and traffic counters.
module data_mem_responder #(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  input  logic            mem_write_en,
  output logic [0:3][7:0] mem_data_out,
  output logic            addr_err,
  output logic [31:0]     rd_count,
  output logic [31:0]     wr_count
);

  localparam int IDX_W = ADDR_BITS - 2;
  localparam int WORDS = 1 << IDX_W;
  localparam int NSTG  = (LATENCY > 1) ? LATENCY - 1 : 1;

  // vld marks stages filled since reset, so a flushed pipeline returns zeros
  // instead of whatever word 0 holds.
  typedef struct packed {
    logic             vld;
    logic             oor;
    logic [IDX_W-1:0] idx;
  } stage_t;

  logic [IDX_W-1:0] addr_idx;
  logic             addr_oor;
  logic             wr_commit;
  stage_t           cur;
  stage_t           src;
  stage_t           stg [NSTG];
  logic [IDX_W-1:0] prev_idx;
  logic             rd_first;
  logic [0:3][7:0]  mem [WORDS];
  logic             unused_byte_offset;

  assign addr_idx           = mem_addr[ADDR_BITS-1:2];
  assign addr_oor           = |mem_addr[31:ADDR_BITS];
  assign wr_commit          = mem_write_en && !addr_oor;
  assign cur                = '{vld: 1'b1, oor: addr_oor, idx: addr_idx};
  assign unused_byte_offset = ^mem_addr[1:0];

  generate
    if (LATENCY == 1) begin : g_direct
      assign src = cur;
    end else begin : g_staged
      assign src = stg[NSTG-1];
    end
  endgenerate

  // NOTE: storage is deliberately left out of reset so it maps onto RAM; the
  // reset branch only blocks commits on an edge that coincides with rst_b low.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
    end else if (wr_commit) begin
      mem[addr_idx] <= mem_data_in;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values and the shift chain moves exactly one stage per edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NSTG; i++) stg[i] <= '0;
      mem_data_out <= '0;
      addr_err     <= 1'b0;
      rd_count     <= '0;
      wr_count     <= '0;
      prev_idx     <= '0;
      rd_first     <= 1'b1;
    end else begin
      stg[0] <= cur;
      for (int i = 1; i < NSTG; i++) stg[i] <= stg[i-1];

      if (!src.vld || src.oor)
        mem_data_out <= '0;
      else if (wr_commit && (addr_idx == src.idx))
        mem_data_out <= mem_data_in;
      else
        mem_data_out <= mem[src.idx];

      if (addr_oor) addr_err <= 1'b1;
      if (wr_commit) wr_count <= wr_count + 32'd1;
      if (rd_first || (addr_idx != prev_idx)) rd_count <= rd_count + 32'd1;
      prev_idx <= addr_idx;
      rd_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected read data queued at address
// presentation and compared LATENCY cycles later; counters tracked by a small model.
module tb_data_mem_responder;

  localparam int LATENCY = 4;

  logic            clk;
  logic            rst_b;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in;
  logic            mem_write_en;
  logic [0:3][7:0] mem_data_out;
  logic            addr_err;
  logic [31:0]     rd_count;
  logic [31:0]     wr_count;

  data_mem_responder #(.ADDR_BITS(16), .LATENCY(LATENCY)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out),
    .addr_err    (addr_err),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb[$];

  logic [31:0] exp_rd;
  logic [31:0] exp_wr;
  logic        exp_err;
  logic [13:0] prev_idx;
  logic        first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_rd   = '0;
    exp_wr   = '0;
    exp_err  = 1'b0;
    prev_idx = '0;
    first    = 1'b1;
  endtask

  // Advance one clock edge, updating the counter/flag model for that edge.
  task automatic tick();
    logic [13:0] idx;
    logic        oor;
    if (rst_b) begin
      idx = mem_addr[15:2];
      oor = |mem_addr[31:16];
      if (first || idx != prev_idx) exp_rd++;
      prev_idx = idx;
      first    = 1'b0;
      if (oor) exp_err = 1'b1;
      else if (mem_write_en) exp_wr++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_rd_count"}, rd_count, exp_rd);
    check({tag, "_wr_count"}, wr_count, exp_wr);
    check({tag, "_addr_err"}, {31'd0, addr_err}, {31'd0, exp_err});
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    mem_addr     = addr;
    mem_data_in  = data;
    mem_write_en = 1'b1;
    tick();
    mem_write_en = 1'b0;
  endtask

  // Present an address for LATENCY+1 cycles; data checked in cycle LATENCY.
  task automatic read_word(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    mem_addr = addr;
    sb.push_back(exp);
    repeat (LATENCY) tick();
    check(tag, mem_data_out, sb.pop_front());
    tick();
  endtask

  initial begin
    rst_b        = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    model_reset();
    repeat (2) tick();
    check("reset_data", mem_data_out, 32'h0);
    check_status("reset");
    rst_b = 1'b1;

    write_word(32'h0000_0000, 32'hCAFE_F00D);
    write_word(32'h0000_0100, 32'h1122_3344);
    check_status("after_writes");
    read_word("rd_100", 32'h0000_0100, 32'h1122_3344);

    read_word("rd_000", 32'h0000_0000, 32'hCAFE_F00D);
    read_word("rd_103", 32'h0000_0103, 32'h1122_3344);
    check("rd_103_lane3", {24'd0, mem_data_out[3]}, 32'h44);
    check_status("after_103");

    // Byte-store emulation: read, then write the merged word in cycle 4.
    mem_addr = 32'h0000_0101;
    sb.push_back(32'h1122_3344);
    repeat (LATENCY) tick();
    check("bytestore_read", mem_data_out, sb.pop_front());
    mem_data_in  = 32'h11AB_3344;
    mem_write_en = 1'b1;
    tick();
    mem_write_en = 1'b0;
    read_word("bytestore_result", 32'h0000_0100, 32'h11AB_3344);
    check_status("after_bytestore");

    // Forwarding: a write at the output stage's source word wins over old storage.
    write_word(32'h0000_0200, 32'h0102_0304);
    read_word("fwd_old", 32'h0000_0000, 32'hCAFE_F00D);
    mem_addr = 32'h0000_0200;
    sb.push_back(32'hDEAD_BEEF);
    repeat (LATENCY - 1) tick();
    mem_data_in  = 32'hDEAD_BEEF;
    mem_write_en = 1'b1;
    tick();
    mem_write_en = 1'b0;
    check("fwd_cycle4", mem_data_out, sb.pop_front());
    tick();
    check("fwd_cycle5", mem_data_out, 32'hDEAD_BEEF);
    check_status("after_fwd");

    // Out-of-range write is dropped and sets the sticky flag.
    write_word(32'h0001_0000, 32'hFFFF_FFFF);
    check("oor_err_set", {31'd0, addr_err}, 32'd1);
    check_status("after_oor_write");
    read_word("oor_read", 32'h0001_0000, 32'h0);
    read_word("oor_word0", 32'h0000_0000, 32'hCAFE_F00D);
    check_status("after_oor_reads");

    // Reset mid-read: flush immediately; a write on the reset edge is not committed.
    mem_addr = 32'h0000_0100;
    repeat (2) tick();
    rst_b        = 1'b0;
    mem_data_in  = 32'h5555_5555;
    mem_write_en = 1'b1;
    model_reset();
    #1;
    check("midreset_data", mem_data_out, 32'h0);
    check_status("midreset");
    tick();
    mem_write_en = 1'b0;
    rst_b        = 1'b1;
    sb.push_back(32'h11AB_3344);
    for (int c = 1; c < LATENCY; c++) begin
      tick();
      check($sformatf("postreset_zero_c%0d", c), mem_data_out, 32'h0);
    end
    tick();
    check("postreset_data", mem_data_out, sb.pop_front());
    check_status("postreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Byte-lane data memory that answers the MIPS core's data-port requests: the responder end of the core's mem_addr / mem_data_in / mem_data_out / mem_write_en interface.
- Word-organised, big-endian lanes, fixed read latency of LATENCY cycles, matching the core's 4-cycle memory stall.
- Single-cycle write commit with write-first forwarding into the read pipeline, so the core's read-modify-write byte store sees consistent data.
- Out-of-range detection, plus read and write transaction counters for the testbench.

Parameters:
- ADDR_BITS, 16: implemented byte-address width (2^ADDR_BITS bytes); must be at least 3.
- LATENCY, 4: cycles from the address cycle to valid read data; must be at least 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- mem_addr  input  32  byte address from the core.
- mem_data_in  input  8x[0:3]  write lanes; lane i is byte (word base + i).
- mem_write_en  input  1  write strobe, one cycle per write.
- mem_data_out  output  8x[0:3]  read lanes; lane i is byte (word base + i).
- addr_err  output  1  sticky out-of-range flag.
- rd_count  output  32  number of address changes accepted as reads.
- wr_count  output  32  number of committed writes.

Behaviour:
- Word base is {mem_addr[ADDR_BITS-1:2], 2'b00]}; mem_addr[1:0] is ignored by the memory.
- All 4 lanes are always returned; lane selection is the core's job.
- Storage is 2^(ADDR_BITS-2) words of 4 bytes.
- Reset does not clear storage; reset clears only the pipeline, outputs and counters.
- Out-of-range: mem_addr[31:ADDR_BITS] != 0.
  - The request reads as all-zero lanes.
  - A write to it is dropped and wr_count does not increment.
  - addr_err is set at the edge that samples the bad address and is cleared only by rst_b.
- Read pipeline:
  - LATENCY-1 address stages (each holds word index plus an out-of-range bit), followed by the output data register.
  - If the address is presented in cycle n, mem_data_out is valid throughout cycle n+LATENCY.
  - The output register loads storage[stage LATENCY-1 address] at each edge. For LATENCY=1 it loads storage[mem_addr word] directly.
  - The pipeline advances every cycle unconditionally; there is no enable and no handshake.
  - The core holds the address for LATENCY+1 cycles.
- Write:
  - When mem_write_en=1 at a rising edge with an in-range address, all 4 lanes of mem_data_in are written to the word at that edge.
  - There is no byte mask; the core merges byte stores itself.
- Write-first forwarding: if the output register's source word is written at the same edge, the register loads mem_data_in instead of old storage.
  - Writes to words currently held in earlier address stages need no special handling, because storage is read at the output stage.
- Counters (wrap at 2^32):
  - rd_count increments at each edge where the mem_addr word index differs from the index sampled at the previous edge.
  - The first edge after reset counts as a change.
  - wr_count increments once per committed write.
- Reset values: mem_data_out lanes 0x00, addr_err 0, rd_count 0, wr_count 0, all address stages word 0 / in-range.
- Reset asserted mid-read: the pipeline is flushed immediately and asynchronously.
  - mem_data_out stays 0x00 until LATENCY cycles after the first post-reset address.
  - A write whose edge coincides with rst_b low is not committed.
- Simultaneous write and address change in the same cycle: the write goes to the address present in that cycle.
- The address stages are a shift chain; there is no wrap-around. A word index of 2^(ADDR_BITS-2)-1 followed by 0 is handled normally.
- mem_write_en held high for several cycles commits on every edge, each to the current address. This is legal but unused by the core.

Test Plan:
- Reset, then write 0x11223344 at addr 0x100 (one-cycle strobe), then hold addr 0x100 for 5 cycles -> mem_data_out = {0x11,0x22,0x33,0x44} in cycle 4 after presentation; wr_count=1.
- Read 0x103 after the previous write -> same 4 lanes as 0x100, lane 3 = 0x44; rd_count increments only once while 0x103 is held.
- Byte store emulation: hold 0x101, read {11,22,33,44}, then in cycle 4 write {11,0xAB,33,44} -> a subsequent read of 0x100 returns {0x11,0xAB,0x33,0x44}.
- Forwarding: hold 0x200, write 0xDEADBEEF at 0x200 in cycle 3 -> mem_data_out in cycle 4 = {DE,AD,BE,EF}, not the stale contents.
- Out-of-range: addr 0x0001_0000 with write 0xFFFFFFFF -> addr_err=1 from the next edge and stays 1; wr_count unchanged; read of 0x0001_0000 returns 0; read of 0x0000_0000 is unaffected.
- Reset mid-read: present 0x100, drop rst_b in cycle 2 for 1 cycle -> mem_data_out=0 and counters=0 immediately; contents of 0x100 still readable afterwards with full LATENCY.
